// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//   PAL raster timing source for the scandoubler/SCART stage. Runs the beam
//   counters at the lores pixel clock and produces active-low sync, blanking
//   and a colour-bar test pattern. With interlace enabled, fields alternate
//   long/short, and short fields carry a half-line vsync offset.
//
// Ports
//   clk                in   pixel clock, the only clock
//   reset              in   synchronous, active-high
//   interlace          in   interlace enable, sampled only at end of field
//   hpos, vpos         out  beam position (9 bits each)
//   lof                out  1 = current field is long
//   _hsync, _vsync     out  active-low syncs
//   blank              out  1 = outside the active picture
//   eol, eof           out  last clock of line / last clock of field
//   red, green, blue   out  4-bit test pattern pixel data
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int HTOTAL = 454,
    parameter int HSSTRT = 36,
    parameter int HSSTOP = 70,
    parameter int HBSTRT = 30,
    parameter int HBSTOP = 106,
    parameter int VTOTAL = 312,
    parameter int VSSTRT = 2,
    parameter int VSSTOP = 5,
    parameter int VBSTOP = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       interlace,
    output logic [8:0] hpos,
    output logic [8:0] vpos,
    output logic       lof,
    output logic       _hsync,
    output logic       _vsync,
    output logic       blank,
    output logic       eol,
    output logic       eof,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    localparam logic [8:0] H_LAST     = 9'(HTOTAL - 1);
    localparam logic [8:0] H_HALF     = 9'(HTOTAL / 2);
    localparam logic [8:0] H_SSTRT    = 9'(HSSTRT);
    localparam logic [8:0] H_SSTOP    = 9'(HSSTOP);
    localparam logic [8:0] H_BSTRT    = 9'(HBSTRT);
    localparam logic [8:0] H_BSTOP    = 9'(HBSTOP);
    localparam logic [8:0] V_LONG_LST = 9'(VTOTAL);
    localparam logic [8:0] V_SHRT_LST = 9'(VTOTAL - 1);
    localparam logic [8:0] V_SSTRT    = 9'(VSSTRT);
    localparam logic [8:0] V_SSTOP    = 9'(VSSTOP);
    localparam logic [8:0] V_BSTOP    = 9'(VBSTOP);

    logic [8:0] r_hpos, r_vpos;
    logic       r_lof, r_hsync_n, r_vsync_n, r_blank, r_eol, r_eof;
    logic [3:0] r_red, r_green, r_blue;

    logic       w_at_eol, w_at_eof;
    logic [8:0] w_hpos_nx, w_vpos_nx, w_vlast_nx, w_vs_h;
    logic       w_lof_nx, w_eol_nx, w_eof_nx;
    logic       w_vs_after, w_vs_before;
    logic       w_hsync_n_nx, w_vsync_n_nx, w_blank_nx;
    logic [2:0] w_bar;
    logic [3:0] w_red_nx, w_green_nx, w_blue_nx;

    // All decodes are computed from the next count values and registered
    // alongside the counters, so every output lines up with hpos/vpos.
    always_comb begin
        w_at_eol  = (r_hpos == H_LAST);
        w_at_eof  = w_at_eol && (r_vpos == (r_lof ? V_LONG_LST : V_SHRT_LST));

        w_hpos_nx = w_at_eol ? 9'd0 : r_hpos + 9'd1;
        w_vpos_nx = r_vpos;
        w_lof_nx  = r_lof;
        if (w_at_eof) begin
            w_vpos_nx = 9'd0;
            // interlace only matters here, at the field boundary
            w_lof_nx  = interlace ? ~r_lof : 1'b1;
        end else if (w_at_eol) begin
            w_vpos_nx = r_vpos + 9'd1;
        end

        w_vlast_nx = w_lof_nx ? V_LONG_LST : V_SHRT_LST;
        w_eol_nx   = (w_hpos_nx == H_LAST);
        w_eof_nx   = w_eol_nx && (w_vpos_nx == w_vlast_nx);

        // A short field can only exist when interlace was set at the last
        // field boundary, so lof=0 alone selects the half-line vsync offset.
        w_vs_h      = w_lof_nx ? 9'd0 : H_HALF;
        w_vs_after  = (w_vpos_nx > V_SSTRT) ||
                      ((w_vpos_nx == V_SSTRT) && (w_hpos_nx >= w_vs_h));
        w_vs_before = (w_vpos_nx < V_SSTOP) ||
                      ((w_vpos_nx == V_SSTOP) && (w_hpos_nx < w_vs_h));
        w_vsync_n_nx = ~(w_vs_after && w_vs_before);

        w_hsync_n_nx = ~((w_hpos_nx >= H_SSTRT) && (w_hpos_nx < H_SSTOP));
        w_blank_nx   = ((w_hpos_nx >= H_BSTRT) && (w_hpos_nx < H_BSTOP)) ||
                       (w_vpos_nx < V_BSTOP);

        w_bar      = w_hpos_nx[8:6];
        w_red_nx   = w_blank_nx ? 4'h0 : {4{w_bar[1]}};
        w_green_nx = w_blank_nx ? 4'h0 : {4{w_bar[2]}};
        w_blue_nx  = w_blank_nx ? 4'h0 : {4{w_bar[0]}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hpos    <= 9'd0;
            r_vpos    <= 9'd0;
            r_lof     <= 1'b1;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_blank   <= 1'b1;
            r_eol     <= 1'b0;
            r_eof     <= 1'b0;
            r_red     <= 4'h0;
            r_green   <= 4'h0;
            r_blue    <= 4'h0;
        end else begin
            r_hpos    <= w_hpos_nx;
            r_vpos    <= w_vpos_nx;
            r_lof     <= w_lof_nx;
            r_hsync_n <= w_hsync_n_nx;
            r_vsync_n <= w_vsync_n_nx;
            r_blank   <= w_blank_nx;
            r_eol     <= w_eol_nx;
            r_eof     <= w_eof_nx;
            r_red     <= w_red_nx;
            r_green   <= w_green_nx;
            r_blue    <= w_blue_nx;
        end
    end

    assign hpos   = r_hpos;
    assign vpos   = r_vpos;
    assign lof    = r_lof;
    assign _hsync = r_hsync_n;
    assign _vsync = r_vsync_n;
    assign blank  = r_blank;
    assign eol    = r_eol;
    assign eof    = r_eof;
    assign red    = r_red;
    assign green  = r_green;
    assign blue   = r_blue;

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
//   Two instances share one clock:
//     u_a - default PAL parameters: reset values, line timing, vsync window,
//           test pattern and mid-frame reset.
//     u_b - VTOTAL=12, VBSTOP=4: field sequencing with interlace on/off,
//           long/short field lengths, half-line vsync and lof behaviour.
//   Expected values are pushed into per-instance queues keyed by cycle
//   number; the monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int HT = 454;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a = 1'b1, rst_b = 1'b1;
    logic il_a = 1'b0, il_b = 1'b1;

    logic [8:0] a_hpos, a_vpos, b_hpos, b_vpos;
    logic       a_lof, a_hs, a_vs, a_blank, a_eol, a_eof;
    logic       b_lof, b_hs, b_vs, b_blank, b_eol, b_eof;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;

    video_timing_gen u_a (
        .clk(clk), .reset(rst_a), .interlace(il_a),
        .hpos(a_hpos), .vpos(a_vpos), .lof(a_lof),
        ._hsync(a_hs), ._vsync(a_vs), .blank(a_blank),
        .eol(a_eol), .eof(a_eof), .red(a_r), .green(a_g), .blue(a_b)
    );

    video_timing_gen #(.VTOTAL(12), .VBSTOP(4)) u_b (
        .clk(clk), .reset(rst_b), .interlace(il_b),
        .hpos(b_hpos), .vpos(b_vpos), .lof(b_lof),
        ._hsync(b_hs), ._vsync(b_vs), .blank(b_blank),
        .eol(b_eol), .eof(b_eof), .red(b_r), .green(b_g), .blue(b_b)
    );

    // ---------------- scoreboard ----------------
    // entry = {cycle[31:0], selector[3:0], value[8:0]}
    localparam int EW = 45;
    logic [EW-1:0] exp_a_q[$];
    logic [EW-1:0] exp_b_q[$];
    int unsigned base_a = 0, base_b = 0;
    int n_checks = 0;
    int n_fail = 0;

    localparam int S_HPOS = 0, S_VPOS = 1, S_LOF = 2, S_HS = 3, S_VS = 4,
                   S_BLANK = 5, S_EOL = 6, S_EOF = 7, S_R = 8, S_G = 9, S_B = 10;

    function automatic string sig_name(int sel);
        case (sel)
            S_HPOS:  return "hpos";
            S_VPOS:  return "vpos";
            S_LOF:   return "lof";
            S_HS:    return "_hsync";
            S_VS:    return "_vsync";
            S_BLANK: return "blank";
            S_EOL:   return "eol";
            S_EOF:   return "eof";
            S_R:     return "red";
            S_G:     return "green";
            default: return "blue";
        endcase
    endfunction

    function automatic logic [8:0] get_sig(bit inst, int sel);
        case (sel)
            S_HPOS:  return inst ? b_hpos : a_hpos;
            S_VPOS:  return inst ? b_vpos : a_vpos;
            S_LOF:   return 9'(inst ? b_lof : a_lof);
            S_HS:    return 9'(inst ? b_hs : a_hs);
            S_VS:    return 9'(inst ? b_vs : a_vs);
            S_BLANK: return 9'(inst ? b_blank : a_blank);
            S_EOL:   return 9'(inst ? b_eol : a_eol);
            S_EOF:   return 9'(inst ? b_eof : a_eof);
            S_R:     return 9'(inst ? b_r : a_r);
            S_G:     return 9'(inst ? b_g : a_g);
            default: return 9'(inst ? b_b : a_b);
        endcase
    endfunction

    task automatic push(bit inst, int k, int sel, int val);
        if (inst) exp_b_q.push_back({32'(base_b + k), 4'(sel), 9'(val)});
        else      exp_a_q.push_back({32'(base_a + k), 4'(sel), 9'(val)});
    endtask

    task automatic check_entry(bit inst, logic [EW-1:0] e);
        logic [8:0] got;
        got = get_sig(inst, int'(e[12:9]));
        n_checks++;
        if (e[44:13] != cyc) begin
            n_fail++;
            $display("FAIL %s.%s stale entry for cycle %0d at cycle %0d",
                     inst ? "b" : "a", sig_name(int'(e[12:9])), e[44:13], cyc);
        end else if (got !== e[8:0]) begin
            n_fail++;
            $display("FAIL %s.%s cycle %0d (hpos=%0d vpos=%0d): got %0d expected %0d",
                     inst ? "b" : "a", sig_name(int'(e[12:9])), cyc,
                     inst ? b_hpos : a_hpos, inst ? b_vpos : a_vpos, got, e[8:0]);
        end
    endtask

    always @(negedge clk) begin
        while (exp_a_q.size() > 0 && exp_a_q[0][44:13] <= cyc)
            check_entry(1'b0, exp_a_q.pop_front());
        while (exp_b_q.size() > 0 && exp_b_q[0][44:13] <= cyc)
            check_entry(1'b1, exp_b_q.pop_front());
    end

    // ---------------- driver helpers ----------------
    task automatic wait_cyc(int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_reset_vals(bit inst, int k);
        push(inst, k, S_HPOS, 0);  push(inst, k, S_VPOS, 0);
        push(inst, k, S_LOF, 1);   push(inst, k, S_HS, 1);
        push(inst, k, S_VS, 1);    push(inst, k, S_BLANK, 1);
        push(inst, k, S_EOL, 0);   push(inst, k, S_EOF, 0);
        push(inst, k, S_R, 0);     push(inst, k, S_G, 0);
        push(inst, k, S_B, 0);
    endtask

    // ---------------- instance a: default PAL ----------------
    task automatic run_a();
        int h, v, bar, bl;
        int k_rst;
        k_rst = 150 * HT + 300;
        repeat (3) @(posedge clk);
        #1;
        rst_a  = 1'b0;
        base_a = cyc;

        // lines 0..6: counting, eol, wrap, hsync, vsync window (2,0)..(5,0)
        push_reset_vals(1'b0, 0);
        for (int k = 1; k < 7 * HT; k++) begin
            h = k % HT;
            v = k / HT;
            push(1'b0, k, S_HPOS, h);
            push(1'b0, k, S_VPOS, v);
            push(1'b0, k, S_EOL, (h == HT - 1) ? 1 : 0);
            push(1'b0, k, S_EOF, 0);
            push(1'b0, k, S_HS, (h >= 36 && h < 70) ? 0 : 1);
            push(1'b0, k, S_VS, (k >= 2 * HT && k < 5 * HT) ? 0 : 1);
            push(1'b0, k, S_BLANK, 1);
        end

        // vertically blanked line: pattern suppressed
        push(1'b0, 10 * HT + 128, S_BLANK, 1);
        push(1'b0, 10 * HT + 128, S_R, 0);
        push(1'b0, 10 * HT + 128, S_G, 0);
        push(1'b0, 10 * HT + 128, S_B, 0);

        // active line 30: horizontal blank window and colour bars
        for (h = 0; h < HT; h++) begin
            bl  = (h >= 30 && h < 106) ? 1 : 0;
            bar = h / 64;
            push(1'b0, 30 * HT + h, S_HPOS, h);
            push(1'b0, 30 * HT + h, S_BLANK, bl);
            push(1'b0, 30 * HT + h, S_HS, (h >= 36 && h < 70) ? 0 : 1);
            push(1'b0, 30 * HT + h, S_R, (bl == 0 && ((bar >> 1) & 1) == 1) ? 15 : 0);
            push(1'b0, 30 * HT + h, S_G, (bl == 0 && ((bar >> 2) & 1) == 1) ? 15 : 0);
            push(1'b0, 30 * HT + h, S_B, (bl == 0 && (bar & 1) == 1) ? 15 : 0);
        end

        // active pixel hpos=128 vpos=100: bar 2 -> pure red
        push(1'b0, 100 * HT + 128, S_BLANK, 0);
        push(1'b0, 100 * HT + 128, S_R, 15);
        push(1'b0, 100 * HT + 128, S_G, 0);
        push(1'b0, 100 * HT + 128, S_B, 0);

        // mid-frame reset at (300,150)
        push(1'b0, k_rst, S_HPOS, 300);
        push(1'b0, k_rst, S_VPOS, 150);
        push_reset_vals(1'b0, k_rst + 1);
        push(1'b0, k_rst + 2, S_HPOS, 1);
        push(1'b0, k_rst + 2, S_VPOS, 0);
        push(1'b0, k_rst + 3, S_HPOS, 2);

        wait_cyc(base_a + k_rst);
        rst_a = 1'b1;
        wait_cyc(base_a + k_rst + 1);
        rst_a = 1'b0;
        wait_cyc(base_a + k_rst + 5);
    endtask

    // ---------------- instance b: short fields, interlace ----------------
    task automatic run_b();
        int lens[6] = '{13, 12, 13, 12, 13, 13};
        int lofs[6] = '{1, 0, 1, 0, 1, 1};
        int ks, L, h0;
        repeat (4) @(posedge clk);
        #1;
        rst_b  = 1'b0;
        base_b = cyc;

        ks = 0;
        for (int f = 0; f < 6; f++) begin
            L  = lens[f];
            h0 = (lofs[f] == 1) ? 0 : HT / 2;
            push(1'b1, ks, S_LOF, lofs[f]);
            push(1'b1, ks, S_VPOS, 0);
            push(1'b1, ks, S_HPOS, 0);
            push(1'b1, ks + 2 * HT + h0 - 1, S_VS, 1);
            push(1'b1, ks + 2 * HT + h0, S_VS, 0);
            push(1'b1, ks + 3 * HT + 35, S_HS, 1);
            push(1'b1, ks + 3 * HT + 36, S_HS, 0);
            push(1'b1, ks + 3 * HT + 69, S_HS, 0);
            push(1'b1, ks + 3 * HT + 70, S_HS, 1);
            push(1'b1, ks + 5 * HT + h0 - 1, S_VS, 0);
            push(1'b1, ks + 5 * HT + h0, S_VS, 1);
            push(1'b1, ks + (L - 1) * HT - 1, S_EOL, 1);
            push(1'b1, ks + (L - 1) * HT - 1, S_EOF, 0);
            push(1'b1, ks + (L - 1) * HT - 1, S_VPOS, L - 2);
            push(1'b1, ks + L * HT - 2, S_EOF, 0);
            push(1'b1, ks + L * HT - 1, S_EOF, 1);
            push(1'b1, ks + L * HT - 1, S_EOL, 1);
            push(1'b1, ks + L * HT - 1, S_VPOS, L - 1);
            push(1'b1, ks + L * HT - 1, S_HPOS, HT - 1);
            ks += L * HT;
        end
        push(1'b1, ks, S_LOF, 1);
        push(1'b1, ks, S_VPOS, 0);

        // field 3 (short): drop interlace after its vsync lines
        wait_cyc(base_b + 38 * HT + 8 * HT);
        il_b = 1'b0;
        // field 4: a mid-field interlace pulse must not affect lof
        wait_cyc(base_b + 50 * HT + 8 * HT);
        il_b = 1'b1;
        wait_cyc(base_b + 50 * HT + 9 * HT);
        il_b = 1'b0;
        wait_cyc(base_b + ks + 3);
    endtask

    // ---------------- main / report ----------------
    initial begin
        fork
            run_a();
            run_b();
        join
        repeat (2) @(posedge clk);
        #1;
        while (exp_a_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a.unchecked entry for cycle %0d never compared", exp_a_q[0][44:13]);
            void'(exp_a_q.pop_front());
        end
        while (exp_b_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b.unchecked entry for cycle %0d never compared", exp_b_q[0][44:13]);
            void'(exp_b_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
